// File: rtl/bht_predictor_if.sv
// bht_predictor_if: fetch-side prediction request/response and execute-side resolve bundle.
// Latency: none; plain wires between the pipeline stages and the predictor.
// Backpressure: none; the predictor accepts a request and an update every cycle.
interface bht_predictor_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CTR_WIDTH = 2
);
  logic                 pred_valid;
  logic [PC_WIDTH-1:0]  pred_pc;
  logic                 pred_out_valid;
  logic                 pred_taken;
  logic [CTR_WIDTH-1:0] pred_ctr;
  logic                 upd_valid;
  logic [PC_WIDTH-1:0]  upd_pc;
  logic                 upd_actual;

  // Pipeline side: issues requests and resolves, consumes predictions.
  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_actual,
    input  pred_out_valid, pred_taken, pred_ctr
  );

  // Predictor side.
  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_actual,
    output pred_out_valid, pred_taken, pred_ctr
  );
endinterface

// File: rtl/bht_predictor.sv
// bht_predictor: 2**INDEX_BITS saturating counters indexed by PC; GSHARE_EN XORs global history into the index.
// Latency: prediction registered 1 cycle after pred_valid; updates commit on the same posedge, write-first to a same-cycle read.
// Backpressure: none; one prediction and one update accepted every cycle.
module bht_predictor #(
  parameter int CTR_WIDTH  = 2,
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int HIST_BITS  = 6
) (
  input logic            clk,
  input logic            reset,
  bht_predictor_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  // Weakly-not-taken start value: 01 for 2-bit counters, 0 for 1-bit.
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};

  // Register array rather than RAM: every entry must clear on the async reset.
  logic [CTR_WIDTH-1:0]  ctr_tbl [DEPTH];
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [CTR_WIDTH-1:0]  upd_cur;
  logic [CTR_WIDTH-1:0]  upd_next;
  logic [CTR_WIDTH-1:0]  pred_rd;

  // Only pc[INDEX_BITS+1:2] selects an entry; the rest of the PC is deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{bus.pred_pc, bus.upd_pc, (HIST_BITS > 0)};

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0]  ghr;
  logic [HIST_BITS-1:0]  ghr_next;
  logic [INDEX_BITS-1:0] ghr_ext;

  assign ghr_ext = INDEX_BITS'(ghr);

  // Both ports hash with the history as it stood before this cycle's shift.
  assign pred_idx = bus.pred_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign upd_idx  = bus.upd_pc[INDEX_BITS+1:2] ^ ghr_ext;

  if (HIST_BITS == 1) begin : g_ghr_one
    assign ghr_next = bus.upd_actual;
  end else begin : g_ghr_shift
    assign ghr_next = {ghr[HIST_BITS-2:0], bus.upd_actual};
  end

  // Shift each resolved outcome into the global history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (bus.upd_valid) begin
      ghr <= ghr_next;
    end
  end
`else
  assign pred_idx = bus.pred_pc[INDEX_BITS+1:2];
  assign upd_idx  = bus.upd_pc[INDEX_BITS+1:2];
`endif

  // Saturating step of the entry being resolved; no wrap at either end.
  always_comb begin
    upd_cur  = ctr_tbl[upd_idx];
    upd_next = upd_cur;
    if (bus.upd_actual) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - 1'b1;
    end
  end

  // Write-first read: a same-cycle update to the same entry is forwarded to the prediction.
  always_comb begin
    pred_rd = ctr_tbl[pred_idx];
    if (bus.upd_valid && (upd_idx == pred_idx)) pred_rd = upd_next;
  end

  // Counter table: clear to weakly-not-taken, commit one resolve per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= CTR_INIT;
    end else if (bus.upd_valid) begin
      ctr_tbl[upd_idx] <= upd_next;
    end
  end

  // Registered prediction; value outputs hold while no request is made.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pred_out_valid <= 1'b0;
      bus.pred_taken     <= 1'b0;
      bus.pred_ctr       <= '0;
    end else begin
      bus.pred_out_valid <= bus.pred_valid;
      if (bus.pred_valid) begin
        bus.pred_ctr   <= pred_rd;
        bus.pred_taken <= pred_rd[CTR_WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: directed and random checks of the BHT predictor with a prediction scoreboard.
// Latency: expects each prediction one cycle after its request.
// Backpressure: none; stimulus drives every cycle.
module tb_bht_predictor;
  logic clk;
  logic reset;

  bht_predictor_if #(.PC_WIDTH(32), .CTR_WIDTH(2)) bus ();

  bht_predictor #(
    .CTR_WIDTH(2), .INDEX_BITS(6), .PC_WIDTH(32), .HIST_BITS(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic        ua;
    logic [1:0]  exp;
  } step_t;

  int         n_checks;
  int         n_fail;
  logic [1:0] exp_q[$];
  logic [1:0] m_ctr[64];
`ifdef GSHARE_EN
  logic [5:0] m_ghr;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic step_t st_p(input logic [31:0] pc, input logic [1:0] e);
    return '{1'b1, pc, 1'b0, 32'h0, 1'b0, e};
  endfunction
  function automatic step_t st_u(input logic [31:0] pc, input logic a);
    return '{1'b0, 32'h0, 1'b1, pc, a, 2'b00};
  endfunction
  function automatic step_t st_pu(input logic [31:0] ppc, input logic [31:0] upc,
                                  input logic a, input logic [1:0] e);
    return '{1'b1, ppc, 1'b1, upc, a, e};
  endfunction

  function automatic logic [1:0] m_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [5:0] m_idx(input logic [31:0] pc);
`ifdef GSHARE_EN
    return pc[7:2] ^ m_ghr;
`else
    return pc[7:2];
`endif
  endfunction

  task automatic cycle(input logic pv, input logic [31:0] ppc, input logic uv,
                       input logic [31:0] upc, input logic ua);
    bus.pred_valid = pv;
    bus.pred_pc    = ppc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_actual = ua;
    @(negedge clk);
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
  endtask

  task automatic apply_reset();
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) m_ctr[i] = 2'b01;
`ifdef GSHARE_EN
    m_ghr = '0;
`endif
  endtask

  task automatic test_reset();
    logic [1:0] e;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_actual = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.pred_out_valid !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_ctr !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state got v=%b t=%b ctr=%b want 0 0 00", bus.pred_out_valid, bus.pred_taken, bus.pred_ctr);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(2'b01);
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e || bus.pred_taken !== e[1]) begin
      n_fail++;
      $display("FAIL first_pred got v=%b ctr=%b t=%b want v=1 ctr=%b t=%b", bus.pred_out_valid, bus.pred_ctr, bus.pred_taken, e, e[1]);
    end
    // Dirty a few entries so the readback after reset is meaningful.
    cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h104, 1'b0);
    exp_q.push_back(2'b01);
    cycle(1'b1, 32'h10C, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e) begin
      n_fail++;
      $display("FAIL pre_reset_pred got v=%b ctr=%b want v=1 ctr=%b", bus.pred_out_valid, bus.pred_ctr, e);
    end
    // Mid-cycle async reset with a request pending.
    bus.pred_valid = 1'b1;
    bus.pred_pc    = 32'h100;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.pred_out_valid !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_ctr !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset got v=%b t=%b ctr=%b want 0 0 00", bus.pred_out_valid, bus.pred_taken, bus.pred_ctr);
    end
    @(negedge clk);
    bus.pred_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.pred_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_pred got v=%b want 0", bus.pred_out_valid);
    end
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(2'b01);
      cycle(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e) begin
        n_fail++;
        $display("FAIL readback[%0d] got v=%b ctr=%b want v=1 ctr=%b", i, bus.pred_out_valid, bus.pred_ctr, e);
      end
    end
  endtask

`ifndef GSHARE_EN
  task automatic test_saturate();
    step_t s[$];
    logic [1:0] e, last;
    apply_reset();
    last = 2'b00;
    s.push_back(st_u(32'h100, 1'b1)); s.push_back(st_u(32'h100, 1'b1)); s.push_back(st_u(32'h100, 1'b1));
    s.push_back(st_p(32'h100, 2'b11));
    s.push_back(st_u(32'h100, 1'b1));
    s.push_back(st_p(32'h100, 2'b11));
    s.push_back(st_u(32'h104, 1'b0)); s.push_back(st_u(32'h104, 1'b0)); s.push_back(st_u(32'h104, 1'b0));
    s.push_back(st_p(32'h104, 2'b00));
    s.push_back(st_u(32'h104, 1'b1));
    s.push_back(st_p(32'h104, 2'b01));
    s.push_back(st_u(32'h104, 1'b1));
    s.push_back(st_p(32'h104, 2'b10));
    foreach (s[i]) begin
      if (s[i].pv) exp_q.push_back(s[i].exp);
      cycle(s[i].pv, s[i].ppc, s[i].uv, s[i].upc, s[i].ua);
      n_checks++;
      if (s[i].pv) begin
        e = exp_q.pop_front();
        last = e;
        if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e || bus.pred_taken !== e[1]) begin
          n_fail++;
          $display("FAIL saturate[%0d] got v=%b ctr=%b t=%b want v=1 ctr=%b t=%b", i, bus.pred_out_valid, bus.pred_ctr, bus.pred_taken, e, e[1]);
        end
      end else if (bus.pred_out_valid !== 1'b0 || bus.pred_ctr !== last || bus.pred_taken !== last[1]) begin
        n_fail++;
        $display("FAIL saturate_hold[%0d] got v=%b ctr=%b want v=0 ctr=%b", i, bus.pred_out_valid, bus.pred_ctr, last);
      end
    end
  endtask

  task automatic test_bypass_alias();
    step_t s[$];
    logic [1:0] e, last;
    apply_reset();
    last = 2'b00;
    s.push_back(st_pu(32'h108, 32'h108, 1'b1, 2'b10));
    s.push_back(st_p(32'h108, 2'b10));
    s.push_back(st_pu(32'h108, 32'h10C, 1'b1, 2'b10));
    s.push_back(st_p(32'h10C, 2'b10));
    s.push_back(st_pu(32'h110, 32'h108, 1'b0, 2'b01));
    s.push_back(st_u(32'h100, 1'b1)); s.push_back(st_u(32'h100, 1'b1));
    s.push_back(st_p(32'h000, 2'b11));
    s.push_back(st_u(32'h2100, 1'b0));
    s.push_back(st_p(32'h4000_0100, 2'b10));
    foreach (s[i]) begin
      if (s[i].pv) exp_q.push_back(s[i].exp);
      cycle(s[i].pv, s[i].ppc, s[i].uv, s[i].upc, s[i].ua);
      n_checks++;
      if (s[i].pv) begin
        e = exp_q.pop_front();
        last = e;
        if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e || bus.pred_taken !== e[1]) begin
          n_fail++;
          $display("FAIL bypass_alias[%0d] got v=%b ctr=%b t=%b want v=1 ctr=%b t=%b", i, bus.pred_out_valid, bus.pred_ctr, bus.pred_taken, e, e[1]);
        end
      end else if (bus.pred_out_valid !== 1'b0 || bus.pred_ctr !== last) begin
        n_fail++;
        $display("FAIL bypass_alias_hold[%0d] got v=%b ctr=%b want v=0 ctr=%b", i, bus.pred_out_valid, bus.pred_ctr, last);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [1:0] e;
    apply_reset();
    s.push_back(st_pu(32'h114, 32'h114, 1'b1, 2'b10));
    s.push_back(st_pu(32'h114, 32'h114, 1'b1, 2'b11));
    s.push_back(st_pu(32'h114, 32'h114, 1'b1, 2'b11));
    s.push_back(st_pu(32'h114, 32'h114, 1'b0, 2'b10));
    s.push_back(st_pu(32'h114, 32'h114, 1'b0, 2'b01));
    s.push_back(st_pu(32'h114, 32'h114, 1'b0, 2'b00));
    s.push_back(st_pu(32'h114, 32'h114, 1'b0, 2'b00));
    s.push_back(st_p(32'h114, 2'b00));
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      cycle(s[i].pv, s[i].ppc, s[i].uv, s[i].upc, s[i].ua);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e || bus.pred_taken !== e[1]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got v=%b ctr=%b t=%b want v=1 ctr=%b t=%b", i, bus.pred_out_valid, bus.pred_ctr, bus.pred_taken, e, e[1]);
      end
    end
  endtask
`endif

`ifdef GSHARE_EN
  task automatic test_gshare();
    step_t s[$];
    logic [1:0] e;
    apply_reset();
    s.push_back(st_u(32'h0, 1'b1));
    s.push_back(st_u(32'h0, 1'b1));
    s.push_back(st_p(32'h0, 2'b01));
    s.push_back(st_u(32'h0, 1'b1));
    s.push_back(st_p(32'h0, 2'b01));
    s.push_back(st_p(32'h1C, 2'b10));
    s.push_back(st_p(32'h18, 2'b10));
    s.push_back(st_pu(32'h1C, 32'h1C, 1'b1, 2'b11));
    s.push_back(st_p(32'h0, 2'b01));
    s.push_back(st_p(32'h30, 2'b10));
    foreach (s[i]) begin
      if (s[i].pv) exp_q.push_back(s[i].exp);
      cycle(s[i].pv, s[i].ppc, s[i].uv, s[i].upc, s[i].ua);
      if (s[i].pv) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e || bus.pred_taken !== e[1]) begin
          n_fail++;
          $display("FAIL gshare[%0d] got v=%b ctr=%b t=%b want v=1 ctr=%b t=%b", i, bus.pred_out_valid, bus.pred_ctr, bus.pred_taken, e, e[1]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [1:0]  e, last, nxt;
    logic [5:0]  pi, ui;
    logic        pv, uv, ua;
    logic [31:0] ppc, upc;
    apply_reset();
    last = 2'b00;
    nxt  = 2'b00;
    for (int i = 0; i < 300; i++) begin
      pv  = 1'($urandom_range(0, 1));
      uv  = 1'($urandom_range(0, 1));
      ua  = 1'($urandom_range(0, 1));
      ppc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      upc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      pi  = m_idx(ppc);
      ui  = m_idx(upc);
      if (uv) nxt = m_step(m_ctr[ui], ua);
      if (pv) exp_q.push_back((uv && ui == pi) ? nxt : m_ctr[pi]);
      if (uv) begin
        m_ctr[ui] = nxt;
`ifdef GSHARE_EN
        m_ghr = {m_ghr[4:0], ua};
`endif
      end
      cycle(pv, ppc, uv, upc, ua);
      n_checks++;
      if (pv) begin
        e = exp_q.pop_front();
        last = e;
        if (bus.pred_out_valid !== 1'b1 || bus.pred_ctr !== e || bus.pred_taken !== e[1]) begin
          n_fail++;
          $display("FAIL random[%0d] got v=%b ctr=%b t=%b want v=1 ctr=%b t=%b", i, bus.pred_out_valid, bus.pred_ctr, bus.pred_taken, e, e[1]);
        end
      end else if (bus.pred_out_valid !== 1'b0 || bus.pred_ctr !== last) begin
        n_fail++;
        $display("FAIL random_hold[%0d] got v=%b ctr=%b want v=0 ctr=%b", i, bus.pred_out_valid, bus.pred_ctr, last);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifndef GSHARE_EN
    test_saturate();
    test_bypass_alias();
    test_back_to_back();
`else
    test_gshare();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
